// File: rtl/ctrl_pkg.sv
// Shared definitions for the nibble-processor control stage: opcodes,
// control-state encoding and ALU operation encodings.
package ctrl_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned ALUOP_W = 3;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_LIT  = 4'h1;
    localparam logic [OPC_W-1:0] OP_IN   = 4'h2;
    localparam logic [OPC_W-1:0] OP_OUT  = 4'h3;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'h4;
    localparam logic [OPC_W-1:0] OP_SUBI = 4'h5;
    localparam logic [OPC_W-1:0] OP_ANDI = 4'h6;
    localparam logic [OPC_W-1:0] OP_NORI = 4'h7;
    localparam logic [OPC_W-1:0] OP_CMPI = 4'h8;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'h9;
    localparam logic [OPC_W-1:0] OP_JC   = 4'hA;
    localparam logic [OPC_W-1:0] OP_JNC  = 4'hB;
    localparam logic [OPC_W-1:0] OP_JZ   = 4'hC;
    localparam logic [OPC_W-1:0] OP_JNZ  = 4'hD;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hE;

    localparam logic [ALUOP_W-1:0] ALU_PASSB = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_NOR   = 3'b100;

endpackage

// File: rtl/decode_ctrl_flag_reg.sv
// flag_reg: 2-bit carry/zero register, per-bit flop with load enable.
// Ports: clk, reset (async, active-high), i_ld (load enable),
//        i_d[1:0] (next flag values), o_q[1:0] (registered flags).
module flag_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_ld,
    input  logic [1:0] i_d,
    output logic [1:0] o_q
);

    logic [1:0] r_q;

    // One enabled flop per bit, same shape as the fetch register.
    for (genvar g = 0; g < 2; g++) begin : g_bit
        always_ff @(posedge clk or posedge reset) begin
            if (reset)     r_q[g] <= 1'b0;
            else if (i_ld) r_q[g] <= i_d[g];
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: FETCH/EXEC sequencer and opcode decoder for the 4-bit
// nibble processor; owns the carry/zero flag register.
// Inputs : clk, reset (async, active-high), enable (run/stall),
//          instr[3:0], alu_c, alu_z.
// Outputs: fetch_en, pc_inc, pc_load, acc_we, src_sel, alu_op[2:0], out_we
//          (combinational strobes), carry_q, zero_q (registered flags),
//          halted.
// Build option: define DECODE_CTRL_HALT_EN to make opcode 0xE stop the
// machine; otherwise 0xE is a NOP and halted is tied low.
module decode_ctrl
    import ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [OPC_W-1:0]   instr,
    input  logic               alu_c,
    input  logic               alu_z,
    output logic               fetch_en,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               acc_we,
    output logic               src_sel,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               out_we,
    output logic               carry_q,
    output logic               zero_q,
    output logic               halted
);

    state_t     r_state;
    state_t     w_next;
    logic       w_flag_ld;
    logic       w_take;
    logic [1:0] w_flags;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_FETCH;
        else       r_state <= w_next;
    end

    // Branch condition from the registered flags only.
    always_comb begin
        w_take = 1'b0;
        case (instr)
            OP_JMP:  w_take = 1'b1;
            OP_JC:   w_take = carry_q;
            OP_JNC:  w_take = ~carry_q;
            OP_JZ:   w_take = zero_q;
            OP_JNZ:  w_take = ~zero_q;
            default: w_take = 1'b0;
        endcase
    end

    // Next state and strobes; a stalled cycle leaves everything at default.
    always_comb begin
        w_next    = r_state;
        fetch_en  = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        acc_we    = 1'b0;
        src_sel   = 1'b0;
        alu_op    = ALU_PASSB;
        out_we    = 1'b0;
        w_flag_ld = 1'b0;
        if (enable) begin
            case (r_state)
                ST_FETCH: begin
                    fetch_en = 1'b1;
                    pc_inc   = 1'b1;
                    w_next   = ST_EXEC;
                end
                ST_EXEC: begin
                    w_next = ST_FETCH;
                    case (instr)
                        OP_LIT:  acc_we = 1'b1;
                        OP_IN: begin
                            acc_we  = 1'b1;
                            src_sel = 1'b1;
                        end
                        OP_OUT:  out_we = 1'b1;
                        OP_ADDI: begin
                            acc_we    = 1'b1;
                            alu_op    = ALU_ADD;
                            w_flag_ld = 1'b1;
                        end
                        OP_SUBI: begin
                            acc_we    = 1'b1;
                            alu_op    = ALU_SUB;
                            w_flag_ld = 1'b1;
                        end
                        OP_ANDI: begin
                            acc_we    = 1'b1;
                            alu_op    = ALU_AND;
                            w_flag_ld = 1'b1;
                        end
                        OP_NORI: begin
                            acc_we    = 1'b1;
                            alu_op    = ALU_NOR;
                            w_flag_ld = 1'b1;
                        end
                        OP_CMPI: begin
                            alu_op    = ALU_SUB;
                            w_flag_ld = 1'b1;
                        end
                        // Not-taken jumps still step over the address byte.
                        OP_JMP, OP_JC, OP_JNC, OP_JZ, OP_JNZ: begin
                            pc_load = w_take;
                            pc_inc  = ~w_take;
                        end
`ifdef DECODE_CTRL_HALT_EN
                        OP_HALT: w_next = ST_HALT;
`endif
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    flag_reg u_flag_reg (
        .clk   (clk),
        .reset (reset),
        .i_ld  (w_flag_ld),
        .i_d   ({alu_c, alu_z}),
        .o_q   (w_flags)
    );

    assign carry_q = w_flags[1];
    assign zero_q  = w_flags[0];

`ifdef DECODE_CTRL_HALT_EN
    assign halted = (r_state == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
